// File: rtl/s32x_vdp_bus_initiator_pkg.sv
// Shared types for the 32X VDP bus initiator: target regions, access sizes,
// FSM states and the first-word lane steering helper.
package s32x_vdp_bus_initiator_pkg;

    typedef enum logic [1:0] {
        RGN_REG  = 2'd0,
        RGN_PAL  = 2'd1,
        RGN_DRAM = 2'd2,
        RGN_RSV  = 2'd3
    } rgn_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2
    } sz_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WREL    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Bytes land on the even (high) lane when A0=0 and on the odd (low) lane
    // when A0=1; a long sends its high word first.
    function automatic logic [15:0] first_word(input logic [1:0] sz, input logic a0,
                                               input logic [31:0] wd);
        case (sz)
            SZ_BYTE: return a0 ? {8'h00, wd[7:0]} : {wd[7:0], 8'h00};
            SZ_LONG: return wd[31:16];
            default: return wd[15:0];
        endcase
    endfunction

endpackage

// File: rtl/s32x_vdp_bus_initiator.sv
// Bus-master side of the 32X VDP access protocol: turns one CPU request into
// one or two 16-bit CS/strobe cycles closed by ACK_N, with timeout abort.
module s32x_vdp_bus_initiator
    import s32x_vdp_bus_initiator_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int SETUP   = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic [17:0] REQ_A,
    input  logic [1:0]  REQ_RGN,
    input  logic [1:0]  REQ_SZ,
    input  logic        REQ_WR,
    input  logic [31:0] REQ_WD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic [16:0] A,
    output logic [15:0] DO,
    input  logic [15:0] DI,
    output logic        RD_N,
    output logic        LWR_N,
    output logic        UWR_N,
    output logic        REG_CS_N,
    output logic        PAL_CS_N,
    output logic        DRAM_CS_N,
    input  logic        ACK_N
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] SU_LAST = 8'((SETUP > 0) ? SETUP - 1 : 0);
    localparam state_e     ST_ARM  = (SETUP > 0) ? ST_SETUP : ST_STROBE;

    state_e      state, nxt;
    logic [7:0]  cnt;
    logic        half;
    rgn_e        rgn;
    logic [1:0]  sz;
    logic        wr, a0;
    logic [15:0] wd_lo;

    logic accept, rsv_err, capture, abort_to, finish, next_half, cnt_clr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt       = state;
        accept    = 1'b0;
        rsv_err   = 1'b0;
        capture   = 1'b0;
        abort_to  = 1'b0;
        finish    = 1'b0;
        next_half = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    accept  = 1'b1;
                    cnt_clr = 1'b1;
                    if (REQ_RGN == RGN_RSV) rsv_err = 1'b1;
                    else if (!ACK_N)        nxt = ST_WREL;
                    else                    nxt = ST_ARM;
                end
            end
            ST_WREL: begin
                if (ACK_N) begin
                    nxt     = ST_ARM;
                    cnt_clr = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == SU_LAST) begin
                    nxt     = ST_STROBE;
                    cnt_clr = 1'b1;
                end
            end
            ST_STROBE: begin
                if (!ACK_N) begin
                    capture = 1'b1;
                    nxt     = ST_RELEASE;
                end else if (cnt == TO_LAST) begin
                    abort_to = 1'b1;
                    nxt      = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (ACK_N) begin
                    cnt_clr = 1'b1;
                    if (sz == SZ_LONG && !half) begin
                        next_half = 1'b1;
                        nxt       = ST_ARM;
                    end else begin
                        finish = 1'b1;
                        nxt    = ST_IDLE;
                    end
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Shared by the setup hold and the ACK timeout; only runs where it matters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                   cnt <= '0;
        else if (cnt_clr)                             cnt <= '0;
        else if (state inside {ST_SETUP, ST_STROBE}) cnt <= cnt + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            RDATA <= '0;
            A     <= '0;
            DO    <= '0;
            half  <= 1'b0;
            rgn   <= RGN_REG;
            sz    <= SZ_WORD;
            wr    <= 1'b0;
            a0    <= 1'b0;
            wd_lo <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            if (accept) begin
                rgn   <= rgn_e'(REQ_RGN);
                sz    <= REQ_SZ;
                wr    <= REQ_WR;
                a0    <= REQ_A[0];
                wd_lo <= REQ_WD[15:0];
                half  <= 1'b0;
                RDATA <= '0;
                if (rsv_err) begin
                    DONE <= 1'b1;
                    ERR  <= 1'b1;
                end else begin
                    BUSY <= 1'b1;
                    A    <= REQ_A[17:1];
                    DO   <= first_word(REQ_SZ, REQ_A[0], REQ_WD);
                end
            end
            if (capture && !wr) begin
                case (sz)
                    SZ_BYTE: RDATA[7:0] <= a0 ? DI[7:0] : DI[15:8];
                    SZ_LONG: begin
                        if (!half) RDATA[31:16] <= DI;
                        else       RDATA[15:0]  <= DI;
                    end
                    default: RDATA[15:0] <= DI;
                endcase
            end
            if (next_half) begin
                half <= 1'b1;
                A    <= A + 17'd1;
                DO   <= wd_lo;
            end
            if (finish || abort_to) begin
                BUSY <= 1'b0;
                DONE <= 1'b1;
                ERR  <= abort_to;
            end
        end
    end

    // Selects and strobes decode straight from state so reset drops them at once.
    logic cs_act, strb;
    assign cs_act = (state == ST_SETUP) || (state == ST_STROBE);
    assign strb   = (state == ST_STROBE);

    assign REG_CS_N  = !(cs_act && rgn == RGN_REG);
    assign PAL_CS_N  = !(cs_act && rgn == RGN_PAL);
    assign DRAM_CS_N = !(cs_act && rgn == RGN_DRAM);
    assign RD_N      = !(strb && !wr);
    assign UWR_N     = !(strb && wr && (sz != SZ_BYTE || !a0));
    assign LWR_N     = !(strb && wr && (sz != SZ_BYTE ||  a0));

endmodule

// File: tb/tb_s32x_vdp_bus_initiator.sv
// Directed bench for the VDP bus initiator with a small clocked VDP responder.
module tb_s32x_vdp_bus_initiator;
    import s32x_vdp_bus_initiator_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ = 1'b0;
    logic [17:0] REQ_A = '0;
    logic [1:0]  REQ_RGN = '0;
    logic [1:0]  REQ_SZ = '0;
    logic        REQ_WR = 1'b0;
    logic [31:0] REQ_WD = '0;
    logic        BUSY, DONE, ERR;
    logic [31:0] RDATA;
    logic [16:0] A;
    logic [15:0] DO, DI;
    logic        RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N, ACK_N;

    s32x_vdp_bus_initiator #(.TIMEOUT(64), .SETUP(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_A(REQ_A), .REQ_RGN(REQ_RGN),
        .REQ_SZ(REQ_SZ), .REQ_WR(REQ_WR), .REQ_WD(REQ_WD), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .RDATA(RDATA), .A(A), .DO(DO), .DI(DI), .RD_N(RD_N), .LWR_N(LWR_N),
        .UWR_N(UWR_N), .REG_CS_N(REG_CS_N), .PAL_CS_N(PAL_CS_N), .DRAM_CS_N(DRAM_CS_N),
        .ACK_N(ACK_N)
    );

    always #5 CLK = ~CLK;

    // VDP responder: ACK low ack_dly edges after it sees a strobe, released
    // rel_hold edges after the strobes go away; ack_force pins ACK low.
    int   ack_dly = 1, rel_hold = 0, scnt = 0, hcnt = 0;
    logic ack_n_r = 1'b1, ack_force = 1'b0;
    logic strb_low;
    assign strb_low = !RD_N || !LWR_N || !UWR_N;
    assign ACK_N    = ack_n_r & ~ack_force;
    assign DI       = (A == 17'h00100) ? 16'hAAAA : (A == 17'h00101) ? 16'h5555 : 16'hC33C;

    always @(posedge CLK) begin
        if (strb_low) begin
            scnt <= scnt + 1;
            hcnt <= rel_hold;
            if (ack_dly != 0 && scnt + 1 >= ack_dly) ack_n_r <= 1'b0;
        end else begin
            scnt <= 0;
            if (hcnt > 0) hcnt <= hcnt - 1;
            else          ack_n_r <= 1'b1;
        end
    end

    int   cyc = 0, done_cnt = 0, rd_fall = 0, rd_low = 0;
    logic rd_prev = 1'b1;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        if (!RD_N) rd_low <= rd_low + 1;
        if (!RD_N && rd_prev) rd_fall <= rd_fall + 1;
        rd_prev <= RD_N;
    end

    int errors = 0, checks = 0, t_acc = 0, lat = 0, base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] rgn, input logic [1:0] sz, input logic wr,
                         input logic [17:0] a, input logic [31:0] wd);
        REQ = 1'b1; REQ_RGN = rgn; REQ_SZ = sz; REQ_WR = wr; REQ_A = a; REQ_WD = wd;
        @(negedge CLK);
        REQ = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (DONE !== 1'b1 && n < max) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
        lat = cyc - t_acc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3F);
        chk("rst_flags", {BUSY, DONE, ERR}, 32'h0);
        chk("rst_a_do", {A, DO}, 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        // REG word write
        ack_dly = 1;
        issue(RGN_REG, SZ_WORD, 1'b1, 18'h00008, 32'h0000_1234);
        chk("w_setup_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3B);
        chk("w_setup_a", A, 32'h4);
        @(negedge CLK);
        chk("w_strb_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h23);
        chk("w_strb_do", DO, 32'h1234);
        chk("w_busy", BUSY, 32'h1);
        wait_done("w", 50);
        chk("w_lat", lat, 32'd5);
        chk("w_err_busy", {ERR, BUSY}, 32'h0);
        @(negedge CLK);
        chk("w_done_pulse", DONE, 32'h0);

        // PAL long read, with a stray REQ while busy
        ack_dly = 8;
        base = done_cnt;
        issue(RGN_PAL, SZ_LONG, 1'b0, 18'h00200, 32'h0);
        @(negedge CLK);
        chk("l_rd1_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h1D);
        chk("l_rd1_a", A, 32'h100);
        REQ = 1'b1; REQ_RGN = RGN_REG; REQ_SZ = SZ_WORD; REQ_WR = 1'b1;
        @(negedge CLK);
        REQ = 1'b0;
        for (int n = 0; n < 100 && !(RD_N === 1'b0 && A === 17'h00101); n++) @(negedge CLK);
        chk("l_rd2_a", A, 32'h101);
        chk("l_rd2_rd", RD_N, 32'h0);
        wait_done("l", 100);
        chk("l_rdata", RDATA, 32'hAAAA_5555);
        @(negedge CLK);
        chk("l_single_done", done_cnt - base, 32'd1);
        chk("l_rd_cycles", rd_fall, 32'd2);

        // Byte reads: lane select and zero extension
        ack_dly = 1;
        issue(RGN_REG, SZ_BYTE, 1'b0, 18'h00100, 32'h0);
        wait_done("br0", 50);
        chk("br0_rdata", RDATA, 32'h0000_00C3);
        @(negedge CLK);
        issue(RGN_REG, SZ_BYTE, 1'b0, 18'h00101, 32'h0);
        wait_done("br1", 50);
        chk("br1_rdata", RDATA, 32'h0000_003C);
        @(negedge CLK);

        // DRAM byte writes, odd then even lane
        issue(RGN_DRAM, SZ_BYTE, 1'b1, 18'h00003, 32'hABCD_EF7F);
        @(negedge CLK);
        chk("b3_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h2E);
        chk("b3_do", DO, 32'h007F);
        chk("b3_a", A, 32'h1);
        wait_done("b3", 50);
        @(negedge CLK);
        issue(RGN_DRAM, SZ_BYTE, 1'b1, 18'h00002, 32'hABCD_EF7F);
        @(negedge CLK);
        chk("b2_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h36);
        chk("b2_do", DO, 32'h7F00);
        wait_done("b2", 50);
        @(negedge CLK);

        // Timeout: no ACK at all
        ack_dly = 0;
        base = rd_low;
        issue(RGN_REG, SZ_WORD, 1'b0, 18'h00010, 32'h0);
        wait_done("to", 200);
        chk("to_lat", lat, 32'd65);
        chk("to_err", ERR, 32'h1);
        chk("to_rd_cycles", rd_low - base, 32'd64);
        chk("to_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3F);
        @(negedge CLK);
        ack_dly = 1;
        issue(RGN_REG, SZ_WORD, 1'b1, 18'h00008, 32'h0000_5A5A);
        wait_done("after_to", 50);
        chk("after_to_lat", lat, 32'd5);
        chk("after_to_err", ERR, 32'h0);
        @(negedge CLK);

        // Reserved region
        issue(RGN_RSV, SZ_WORD, 1'b1, 18'h00010, 32'h0);
        chk("rsv_flags", {BUSY, DONE, ERR}, 32'h3);
        chk("rsv_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3F);
        @(negedge CLK);
        chk("rsv_done_pulse", DONE, 32'h0);

        // ACK held low after release, then back-to-back REQ through WREL
        rel_hold = 2;
        issue(RGN_REG, SZ_WORD, 1'b1, 18'h00008, 32'h0000_1111);
        repeat (3) @(negedge CLK);
        chk("rel_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3F);
        chk("rel_busy", {BUSY, DONE}, 32'h2);
        wait_done("rel", 50);
        chk("rel_lat", lat, 32'd7);
        rel_hold = 0;
        ack_force = 1'b1;
        issue(RGN_REG, SZ_WORD, 1'b1, 18'h00008, 32'h0000_2222);
        for (int i = 0; i < 3; i++) begin
            chk("wrel_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3F);
            chk("wrel_busy", BUSY, 32'h1);
            @(negedge CLK);
        end
        ack_force = 1'b0;
        wait_done("wrel", 50);
        chk("wrel_lat", lat, 32'd9);
        @(negedge CLK);

        // Reset in the middle of a long write
        ack_dly = 0;
        base = done_cnt;
        issue(RGN_DRAM, SZ_LONG, 1'b1, 18'h00000, 32'h1122_3344);
        @(negedge CLK);
        chk("rl_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h26);
        chk("rl_do", DO, 32'h1122);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rl_rst_pins", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h3F);
        chk("rl_rst_flags", {BUSY, DONE, ERR}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rl_no_done", done_cnt - base, 32'd0);

        // Fresh long write across the word-address wrap
        ack_dly = 1;
        issue(RGN_DRAM, SZ_LONG, 1'b1, 18'h3FFFE, 32'hCAFE_BABE);
        chk("wr_a1", A, 32'h1FFFF);
        @(negedge CLK);
        chk("wr_do1", DO, 32'hCAFE);
        for (int n = 0; n < 50 && !(LWR_N === 1'b0 && A === 17'h00000); n++) @(negedge CLK);
        chk("wr_a2", A, 32'h0);
        chk("wr_do2", DO, 32'hBABE);
        chk("wr_pins2", {RD_N, LWR_N, UWR_N, REG_CS_N, PAL_CS_N, DRAM_CS_N}, 32'h26);
        wait_done("wr", 50);
        chk("wr_lat", lat, 32'd10);
        chk("wr_err", ERR, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
